// File: rtl/wdog_pkg.sv
// Shared definitions for the watchdog sequence controller: FSM encoding,
// register addresses and the magic read value.
package wdog_pkg;

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, DIS1, DIS2, KK1, KK2
  } seq_state_e;

  localparam logic [3:0] ADDR_STAT = 4'h0;
  localparam logic [3:0] ADDR_EN1  = 4'h1;
  localparam logic [3:0] ADDR_LOAD = 4'h2;
  localparam logic [3:0] ADDR_CNT  = 4'h3;
  localparam logic [3:0] ADDR_KICK = 4'h5;
  localparam logic [3:0] ADDR_RD1  = 4'hA;
  localparam logic [3:0] ADDR_RD2  = 4'hE;
  localparam logic [3:0] ADDR_EN3  = 4'hF;

  localparam logic [31:0] RD_MAGIC = 32'hA5A5_A5A5;

  // Addresses that take part in key sequences; touching them out of order aborts.
  function automatic logic is_seq_addr(input logic [3:0] a);
    return (a == ADDR_EN1) || (a == ADDR_KICK) || (a == ADDR_RD1) ||
           (a == ADDR_RD2) || (a == ADDR_EN3);
  endfunction

endpackage

// File: rtl/wdog_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module wdog_down_counter #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= RST_VAL;
    else if (load_en)       cnt <= load_val;
    else if (dec_en && !zero) cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/wdog_seq_ctrl.sv
// Watchdog controller: validates enable/disable/kick key sequences on the
// register bus, owns the reload value, the down-counter and the timeout flag.
module wdog_seq_ctrl
  import wdog_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter int               SEQ_WIN   = 16,
  parameter logic [31:0]      ENA_KEY   = 32'h0000_0001,
  parameter logic [31:0]      ENA_KEY2  = 32'h0000_000F,
  parameter logic [31:0]      KICK_KEY1 = 32'h0000_00AA,
  parameter logic [31:0]      KICK_KEY2 = 32'h0000_0055,
  parameter logic [CNT_W-1:0] DEF_LOAD  = CNT_W'(32'h0000_FFFF)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WRITE,
  input  logic        READ,
  input  logic [3:0]  ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        TIMER_EN,
  output logic        KICK_OK,
  output logic        SEQ_ERR,
  output logic        TIMEOUT
);

  localparam int WIN_W = $clog2(SEQ_WIN + 1);

  seq_state_e       state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] load, cnt;
  logic [31:0]      rdata_nxt;
  logic wr, rd, w_en1, w_en3, w_kk1, w_kk2, r_rd1, r_rd2;
  logic step, abort, do_en, do_dis, do_kick, cnt_zero, expire;

  assign wr    = WRITE;
  assign rd    = READ && !WRITE;
  assign w_en1 = wr && ADDR == ADDR_EN1  && WDATA == ENA_KEY;
  assign w_en3 = wr && ADDR == ADDR_EN3  && WDATA == ENA_KEY2;
  assign w_kk1 = wr && ADDR == ADDR_KICK && WDATA == KICK_KEY1;
  assign w_kk2 = wr && ADDR == ADDR_KICK && WDATA == KICK_KEY2;
  assign r_rd1 = rd && ADDR == ADDR_RD1;
  assign r_rd2 = rd && ADDR == ADDR_RD2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Window expiry fires on the cycle the count would reach SEQ_WIN.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (!TIMER_EN && w_en1)     state_nxt = EN1;
        else if (TIMER_EN && w_en3) state_nxt = DIS1;
        else if (TIMER_EN && w_kk1) state_nxt = KK1;
      end
      EN1:  begin step = r_rd1; if (step) state_nxt = EN2;  end
      EN2:  begin step = w_en3; if (step) state_nxt = IDLE; end
      DIS1: begin step = r_rd1; if (step) state_nxt = DIS2; end
      DIS2: begin step = w_en1; if (step) state_nxt = IDLE; end
      KK1:  begin step = r_rd2; if (step) state_nxt = KK2;  end
      KK2:  begin step = w_kk2; if (step) state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    abort = (state != IDLE) && !step &&
            (((wr || rd) && is_seq_addr(ADDR)) || win_cnt == WIN_W'(SEQ_WIN - 1));
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    do_en   = (state == EN2)  && step;
    do_dis  = (state == DIS2) && step;
    do_kick = (state == KK2)  && step;
  end

  wdog_down_counter #(.CNT_W(CNT_W), .RST_VAL(DEF_LOAD)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load_en  (do_en || do_kick),
    .load_val (load),
    .dec_en   (TIMER_EN),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // A reload in the same cycle suppresses expiry.
  assign expire = TIMER_EN && !(do_en || do_kick) && (cnt_zero || cnt == CNT_W'(1));

  always_comb begin
    rdata_nxt = '0;
    case (ADDR)
      ADDR_STAT:          rdata_nxt = {29'b0, TIMEOUT, state != IDLE, TIMER_EN};
      ADDR_LOAD:          rdata_nxt = 32'(load);
      ADDR_CNT:           rdata_nxt = 32'(cnt);
      ADDR_RD1, ADDR_RD2: rdata_nxt = RD_MAGIC;
      default:            rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_cnt  <= '0;
      TIMER_EN <= 1'b0;
      KICK_OK  <= 1'b0;
      SEQ_ERR  <= 1'b0;
      TIMEOUT  <= 1'b0;
      load     <= DEF_LOAD;
      RDATA    <= '0;
    end else begin
      win_cnt <= (state == IDLE || step || abort) ? '0 : win_cnt + WIN_W'(1);
      if (do_en)       TIMER_EN <= 1'b1;
      else if (do_dis) TIMER_EN <= 1'b0;
      KICK_OK <= do_kick;
      SEQ_ERR <= abort;
      if (expire) TIMEOUT <= 1'b1;
      if (wr && ADDR == ADDR_LOAD && !TIMER_EN) load <= WDATA[CNT_W-1:0];
      if (rd) RDATA <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_wdog_seq_ctrl.sv
// Directed bench for wdog_seq_ctrl: key sequences, counter expiry, aborts and reset.
module tb_wdog_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WRITE = 1'b0;
  logic        READ = 1'b0;
  logic [3:0]  ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] RDATA;
  logic        TIMER_EN, KICK_OK, SEQ_ERR, TIMEOUT;

  int checks = 0;
  int errors = 0;

  wdog_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .TIMER_EN(TIMER_EN), .KICK_OK(KICK_OK), .SEQ_ERR(SEQ_ERR),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WRITE = 1'b1; ADDR = a; WDATA = d;
    tick();
    WRITE = 1'b0; WDATA = '0;
  endtask

  task automatic rd(input logic [3:0] a);
    READ = 1'b1; ADDR = a;
    tick();
    READ = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_en", TIMER_EN, 0);
    chk("rst_kick", KICK_OK, 0);
    chk("rst_err", SEQ_ERR, 0);
    chk("rst_tmo", TIMEOUT, 0);
    chk("rst_rdata", RDATA, 0);
    RST = 1'b0;
    tick();
    rd(4'h0); chk("stat_rst", RDATA, 32'h0);
    rd(4'h2); chk("load_rst", RDATA, 32'h0000_FFFF);
    rd(4'h3); chk("cnt_rst", RDATA, 32'h0000_FFFF);
    rd(4'hA); chk("magic_a", RDATA, 32'hA5A5_A5A5);
    rd(4'hE); chk("magic_e", RDATA, 32'hA5A5_A5A5);
    rd(4'h4); chk("rd_unmapped", RDATA, 32'h0);

    // enable with load 20, run to expiry
    wr(4'h2, 32'd20);
    wr(4'h1, 32'h1);
    rd(4'h0); chk("stat_locked", RDATA, 32'h2);
    rd(4'hA);
    wr(4'hF, 32'hF);
    chk("en_on", TIMER_EN, 1);
    rd(4'h3); chk("cnt_20", RDATA, 32'd20);
    rd(4'h3); chk("cnt_19", RDATA, 32'd19);
    idle(17); chk("tmo_pre", TIMEOUT, 0);
    idle(1);  chk("tmo_set", TIMEOUT, 1);
    rd(4'h3); chk("cnt_hold0", RDATA, 32'd0);
    rd(4'h0); chk("stat_tmo", RDATA, 32'h5);
    wr(4'h5, 32'hAA); rd(4'hE); wr(4'h5, 32'h55);
    chk("kick_after_tmo", KICK_OK, 1);
    chk("tmo_sticky", TIMEOUT, 1);
    rd(4'h3); chk("cnt_reload20", RDATA, 32'd20);
    chk("kick_pulse_end", KICK_OK, 0);

    // reset, enable with load 100, kick mid-run and at the expiry boundary
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rst2_tmo", TIMEOUT, 0);
    chk("rst2_en", TIMER_EN, 0);
    wr(4'h2, 32'd100);
    wr(4'h1, 32'h1); rd(4'hA); wr(4'hF, 32'hF);
    idle(50);
    wr(4'h5, 32'hAA);
    rd(4'hE); chk("kk_magic", RDATA, 32'hA5A5_A5A5);
    wr(4'h5, 32'h55);
    chk("kick_ok", KICK_OK, 1);
    chk("kick_noerr", SEQ_ERR, 0);
    rd(4'h3); chk("cnt_reload100", RDATA, 32'd100);
    chk("kick_tmo0", TIMEOUT, 0);
    idle(96);
    wr(4'h5, 32'hAA); rd(4'hE); wr(4'h5, 32'h55);
    chk("edge_kick_ok", KICK_OK, 1);
    chk("edge_tmo0", TIMEOUT, 0);
    rd(4'h3); chk("edge_cnt", RDATA, 32'd100);

    // load write ignored while running, then disable freezes counter
    wr(4'h2, 32'd5);
    rd(4'h2); chk("load_locked", RDATA, 32'd100);
    wr(4'hF, 32'hF); rd(4'hA); wr(4'h1, 32'h1);
    chk("dis_off", TIMER_EN, 0);
    rd(4'h3); chk("cnt_frozen_a", RDATA, 32'd94);
    idle(5);
    rd(4'h3); chk("cnt_frozen_b", RDATA, 32'd94);
    rd(4'h0); chk("stat_dis", RDATA, 32'h0);

    // aborts: wrong step, repeated step1, window expiry
    wr(4'h1, 32'h1); rd(4'hE);
    chk("abort_err", SEQ_ERR, 1);
    chk("abort_en", TIMER_EN, 0);
    tick(); chk("abort_pulse_end", SEQ_ERR, 0);
    wr(4'h1, 32'h1); wr(4'h1, 32'h1);
    chk("abort_dup_err", SEQ_ERR, 1);
    rd(4'h0); chk("abort_dup_idle", RDATA, 32'h0);
    wr(4'h1, 32'h1);
    idle(15); chk("win_pre", SEQ_ERR, 0);
    tick();   chk("win_err", SEQ_ERR, 1);
    rd(4'h0); chk("win_idle", RDATA, 32'h0);
    wr(4'h1, 32'h1);
    idle(15);
    rd(4'hA); chk("win_edge_ok", SEQ_ERR, 0);
    wr(4'hF, 32'hF);
    chk("win_edge_en", TIMER_EN, 1);

    // reset in the middle of a kick sequence
    wr(4'h5, 32'hAA); rd(4'hE);
    rd(4'h0); chk("stat_kk2", RDATA, 32'h3);
    #1 RST = 1'b1;
    #1;
    chk("arst_en", TIMER_EN, 0);
    chk("arst_rdata", RDATA, 0);
    chk("arst_kick", KICK_OK, 0);
    chk("arst_err", SEQ_ERR, 0);
    chk("arst_tmo", TIMEOUT, 0);
    tick(); RST = 1'b0;
    rd(4'h0); chk("arst_stat", RDATA, 32'h0);
    wr(4'h5, 32'hAA);
    rd(4'hE); chk("dis_kick_err1", SEQ_ERR, 0);
    wr(4'h5, 32'h55);
    chk("dis_kick_ok", KICK_OK, 0);
    chk("dis_kick_err2", SEQ_ERR, 0);
    rd(4'h2); chk("arst_load", RDATA, 32'h0000_FFFF);
    rd(4'h3); chk("arst_cnt", RDATA, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdog_seq_ctrl.md
Name: wdog_seq_ctrl

Overview:
Controller that sequences the watchdog timer through its unlock, lock and kick key sequences on the 4-bit register bus (CLK domain).
- Validates the three-step enable, disable and kick access sequences and owns the timer enable.
- Owns the reload value and the down-counter, and raises timeout on expiry.
- Sits between the bus decoder and the watchdog reset/interrupt logic.

Parameters:
CNT_W, 32, width of load and counter registers
SEQ_WIN, 16, max CLK cycles allowed between consecutive sequence steps
ENA_KEY, 32'h0000_0001, WDATA for enable step1 (ADDR 0x1) and disable step3
ENA_KEY2, 32'h0000_000F, WDATA for enable step3 (ADDR 0xF) and disable step1
KICK_KEY1, 32'h0000_00AA, WDATA for kick step1 (ADDR 0x5)
KICK_KEY2, 32'h0000_0055, WDATA for kick step3 (ADDR 0x5)
DEF_LOAD, 32'h0000_FFFF, reset value of load register

Ports:
CLK in 1 system clock, rising edge
RST in 1 asynchronous active-high reset
WRITE in 1 write strobe, one access per cycle
READ in 1 read strobe; WRITE wins if both are high
ADDR in 4 register address
WDATA in 32 write data
RDATA out 32 read data, registered, valid the cycle after READ
TIMER_EN out 1 watchdog running
KICK_OK out 1 one-cycle pulse on accepted kick
SEQ_ERR out 1 one-cycle pulse on aborted sequence
TIMEOUT out 1 sticky, counter reached zero while enabled

Behaviour:
- Reset values: all outputs 0, load = DEF_LOAD, counter = DEF_LOAD, FSM = IDLE, window counter = 0.
- Register map, reads:
  - 0x0: {29'b0, TIMEOUT, locked, TIMER_EN}
  - 0x2: load
  - 0x3: counter
  - 0xA and 0xE: 32'hA5A5_A5A5
  - all other addresses: 0
- Load register: write to 0x2 is accepted only when TIMER_EN = 0; ignored otherwise. No error is raised for an ignored load write.
- FSM states: IDLE, EN1, EN2, DIS1, DIS2, KK1, KK2.
- Enable sequence, valid when TIMER_EN = 0:
  - IDLE: write 0x1 with ENA_KEY -> EN1
  - EN1: read 0xA -> EN2
  - EN2: write 0xF with ENA_KEY2 -> TIMER_EN = 1, counter = load, back to IDLE
- Disable sequence, valid when TIMER_EN = 1 (enable in reverse):
  - IDLE: write 0xF with ENA_KEY2 -> DIS1
  - DIS1: read 0xA -> DIS2
  - DIS2: write 0x1 with ENA_KEY -> TIMER_EN = 0, back to IDLE
- Kick sequence, valid when TIMER_EN = 1:
  - IDLE: write 0x5 with KICK_KEY1 -> KK1
  - KK1: read 0xE -> KK2
  - KK2: write 0x5 with KICK_KEY2 -> counter = load, KICK_OK pulse, back to IDLE
- Abort rules, applied while in any non-IDLE state:
  - Any access to 0x1, 0x5, 0xA, 0xE or 0xF other than the expected step aborts: IDLE and SEQ_ERR pulse.
  - Window counter reaching SEQ_WIN with no valid step also aborts the same way.
  - The aborting access is not itself re-evaluated as a step1.
- Window counter: cleared on every accepted step.
- Accesses to 0x0, 0x2, 0x3 never advance or abort a sequence.
- Counter operation while TIMER_EN = 1:
  - Decrements by 1 per CLK.
  - At 0 it holds 0 and sets TIMEOUT; no wrap-around.
  - TIMEOUT clears only on RST. Kick after timeout reloads the counter but TIMEOUT stays 1.
- Simultaneous events: a kick completing in the same cycle the counter would hit 0 -> reload wins, TIMEOUT not set.
- Disable: freezes the counter at its current value.
- RST mid-sequence: immediately IDLE, all state cleared.

Decomposition:
- Package wdog_pkg: FSM state encoding, address constants (ADDR_STAT 0x0, ADDR_LOAD 0x2, ADDR_CNT 0x3, ADDR_EN1 0x1, ADDR_RD1 0xA, ADDR_EN3 0xF, ADDR_KICK 0x5, ADDR_RD2 0xE), read magic value.
- One sub-module, wdog_down_counter: load, decrement, hold at zero, zero flag.
- The FSM and the register decode stay in the top module.

Test Plan:
- Reset then read 0x0 and 0x2 -> RDATA 0 and 0x0000_FFFF; TIMER_EN = 0.
- Write 0x2 = 20, then W1(ENA_KEY), R A, WF(ENA_KEY2) -> TIMER_EN = 1 next cycle, counter reads 20 then decreasing; TIMEOUT = 1 after 20 cycles; counter holds 0.
- Enabled with load 100: run 50 cycles, W5(AA), RE, W5(55) -> KICK_OK pulse, counter reloads to 100, TIMEOUT stays 0.
- Enable step1, then read 0xE instead of 0xA -> SEQ_ERR pulse, TIMER_EN stays 0; repeat with an idle gap of SEQ_WIN cycles after step1 -> SEQ_ERR.
- Enabled: write 0x2 = 5 -> load unchanged. Then WF, RA, W1 -> TIMER_EN = 0 and counter frozen.
- Assert RST while in KK2 -> all outputs 0, FSM IDLE; a later kick attempt with TIMER_EN = 0 -> SEQ_ERR absent, no KICK_OK.
